// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the target loader command path.
package loader_pkg;

    localparam logic [7:0] CMD_HASH    = 8'h48;
    localparam logic [7:0] CMD_CHARSET = 8'h43;
    localparam int unsigned MAX_CHARSET = 64;
    localparam int unsigned HASH_BYTES  = 16;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        S_CMD_IDLE = 2'd0,
        S_HASH     = 2'd1,
        S_CLEN     = 2'd2,
        S_CDATA    = 2'd3
    } cmd_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver with 2-flop synchroniser and mid-bit sampling.
//
//  state    | meaning
//  RX_IDLE  | line idle, waiting for a synced falling edge
//  RX_START | half a bit period in, recheck start bit (false start -> idle)
//  RX_DATA  | sample 8 data bits LSB first, one per bit period
//  RX_STOP  | sample stop bit; high -> byte_valid, low -> frame_err_pulse
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned clock_freq = 16000000,
    parameter int unsigned baud       = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err_pulse,
    output logic       busy
);

    localparam int unsigned BIT_PERIOD = clock_freq / baud;
    localparam int unsigned BW         = $clog2(BIT_PERIOD);
    localparam logic [BW-1:0] BIT_LOAD  = BW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] HALF_LOAD = BW'(BIT_PERIOD / 2 - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_s;
    logic          rx_s_d;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    assign busy = (state != RX_IDLE);

    // Synchronise rx into clk domain and keep one delayed copy for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    // Receive FSM; baud_cnt is a down-counter, each phase acts at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= RX_IDLE;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            shreg           <= '0;
            data            <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_s_d && !rx_s) begin
                        state    <= RX_START;
                        baud_cnt <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (baud_cnt == '0) begin
                        if (!rx_s) begin
                            state    <= RX_DATA;
                            baud_cnt <= BIT_LOAD;
                            bit_cnt  <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == '0) begin
                        shreg    <= {rx_s, shreg[7:1]};
                        baud_cnt <= BIT_LOAD;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= RX_STOP;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == '0) begin
                        if (rx_s) begin
                            data       <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err_pulse <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/target_loader.sv
// Serial command receiver: loads the target hash and writes the charset into bram.
//
//  state      | meaning
//  S_CMD_IDLE | waiting for 'H' or 'C'; other bytes ignored
//  S_HASH     | collecting 16 hash bytes into the shadow register
//  S_CLEN     | waiting for the charset length byte
//  S_CDATA    | writing charset bytes to bram until len reached
module target_loader
    import loader_pkg::*;
#(
    parameter int unsigned clock_freq   = 16000000,
    parameter int unsigned baud         = 115200,
    parameter int unsigned addr_width   = 11,
    parameter int unsigned max_charset  = MAX_CHARSET,
    parameter int unsigned timeout_bits = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic [addr_width-1:0] bram_a,
    output logic                  bram_we,
    output logic [7:0]            bram_di,
    output logic [0:127]          target_hash,
    output logic                  target_valid,
    output logic [6:0]            charset_len,
    output logic                  charset_valid,
    output logic                  frame_err,
    output logic                  rx_led
);

    localparam int unsigned BIT_PERIOD = clock_freq / baud;
    localparam int unsigned TO_CYC     = timeout_bits * BIT_PERIOD;
    localparam int unsigned TW         = $clog2(TO_CYC);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TO_CYC - 1);

    cmd_state_t    state;
    logic [7:0]    rx_data;
    logic          byte_valid;
    logic          rx_err;
    logic [0:127]  shadow;
    logic [6:0]    idx;
    logic [6:0]    len_reg;
    logic [TW-1:0] to_cnt;
    logic          timed_out;

    uart_rx #(
        .clock_freq (clock_freq),
        .baud       (baud)
    ) u_rx (
        .clk             (clk),
        .reset           (reset),
        .rx              (rx),
        .data            (rx_data),
        .byte_valid      (byte_valid),
        .frame_err_pulse (rx_err),
        .busy            (rx_led)
    );

    assign timed_out = (to_cnt == '0) && !byte_valid;

    // Inter-byte timeout: reloaded on every byte and while idle, saturates at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= TO_LOAD;
        end else if (byte_valid || state == S_CMD_IDLE) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    // Command decode, hash assembly and bram write drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_CMD_IDLE;
            shadow        <= '0;
            idx           <= '0;
            len_reg       <= '0;
            bram_a        <= '0;
            bram_we       <= 1'b0;
            bram_di       <= '0;
            target_hash   <= '0;
            target_valid  <= 1'b0;
            charset_len   <= '0;
            charset_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            bram_we <= 1'b0;
            if (rx_err) frame_err <= 1'b1;
            case (state)
                S_CMD_IDLE: begin
                    if (byte_valid) begin
                        if (rx_data == CMD_HASH) begin
                            target_valid <= 1'b0;
                            idx          <= '0;
                            state        <= S_HASH;
                        end else if (rx_data == CMD_CHARSET) begin
                            charset_valid <= 1'b0;
                            state         <= S_CLEN;
                        end
                    end
                end
                S_HASH: begin
                    if (byte_valid) begin
                        shadow <= {shadow[8:127], rx_data};
                        idx    <= idx + 7'd1;
                        if (idx == 7'(HASH_BYTES - 1)) begin
                            target_hash  <= {shadow[8:127], rx_data};
                            target_valid <= 1'b1;
                            state        <= S_CMD_IDLE;
                        end
                    end
                end
                S_CLEN: begin
                    if (byte_valid) begin
                        if (rx_data != 8'd0 && rx_data <= 8'(max_charset)) begin
                            len_reg <= rx_data[6:0];
                            idx     <= '0;
                            state   <= S_CDATA;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_CMD_IDLE;
                        end
                    end
                end
                S_CDATA: begin
                    if (byte_valid) begin
                        bram_a  <= addr_width'(idx);
                        bram_di <= rx_data;
                        bram_we <= 1'b1;
                        idx     <= idx + 7'd1;
                        if (idx + 7'd1 == len_reg) begin
                            charset_len   <= len_reg;
                            charset_valid <= 1'b1;
                            state         <= S_CMD_IDLE;
                        end
                    end
                end
                default: state <= S_CMD_IDLE;
            endcase
            // A bad stop bit or a stalled link abandons whatever command is open.
            if (state != S_CMD_IDLE && (rx_err || timed_out)) begin
                frame_err <= 1'b1;
                state     <= S_CMD_IDLE;
            end
        end
    end

endmodule
